// File: rtl/ifetch.sv
// ifetch: MIPS fetch stage. Owns the PC, keeps one imem request in flight and buffers
// fetched words in a 2-entry IF/ID queue. A redirect flushes the queue and refetches.
module ifetch #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [3:0]         id_op,
    output logic [ADDR_W-1:0]  id_pc,
    input  logic               id_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, addr_q, addr_d;
    logic               req_q, req_d;
    logic [1:0]         occ_q, occ_d, occ_nx;
    logic [INSTR_W-1:0] instr_q [2];
    logic [INSTR_W-1:0] instr_d [2];
    logic [ADDR_W-1:0]  epc_q [2];
    logic [ADDR_W-1:0]  epc_d [2];
    logic               pop, land, pending, wr;

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign id_valid  = occ_q != 2'd0;
    assign id_instr  = instr_q[0];
    assign id_op     = instr_q[0][INSTR_W-1 -: 4];
    assign id_pc     = epc_q[0];

    assign pop     = id_valid & id_ready;
    assign land    = req_q & imem_ack;
    assign pending = req_q & ~imem_ack;
    assign occ_nx  = occ_q + {1'b0, land} - {1'b0, pop};
    // slot for an arriving word: right behind whatever survives this cycle's pop
    assign wr      = occ_q[1] | (occ_q[0] & ~pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        occ_d   = occ_q;
        instr_d = instr_q;
        epc_d   = epc_q;
        if (state_q == DRAIN) begin
            pc_d = redirect_valid ? redirect_pc : pc_q;
            if (land) begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = pc_d;
            end
        end else if (redirect_valid) begin
            occ_d = 2'd0;
            pc_d  = redirect_pc;
            if (pending) begin
                state_d = DRAIN;
            end else begin
                req_d  = 1'b1;
                addr_d = redirect_pc;
            end
        end else begin
            if (pop) begin
                instr_d[0] = instr_q[1];
                epc_d[0]   = epc_q[1];
            end
            if (land) begin
                instr_d[wr] = imem_rdata;
                epc_d[wr]   = addr_q;
                pc_d        = addr_q + 1'b1;
            end
            occ_d = occ_nx;
            if (!pending) begin
                req_d  = occ_nx <= 2'd1;
                addr_d = pc_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            occ_q      <= 2'd0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            epc_q[0]   <= '0;
            epc_q[1]   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            occ_q   <= occ_d;
            instr_q <= instr_d;
            epc_q   <= epc_d;
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed plus randomized bench for ifetch. Decode must see a consecutive
// address stream from the last redirect target; a scoreboard queue holds that stream.
module tb_ifetch;
    localparam logic [7:0] RPC = 8'hFE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [3:0]  id_op;
    logic [7:0]  id_pc;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h0;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int pop_cyc[$];
    int cyc = 0;
    int cnt = 0;
    int ws = 0;
    int cur_ws = 0;
    bit rand_ws = 1'b0;

    ifetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_op(id_op), .id_pc(id_pc), .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [7:0] a);
        return 16'h1000 + {8'h00, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event did not happen within its bound", name);
    endtask

    // expected decode stream: consecutive addresses from the new start point
    task automatic seed(input logic [7:0] start);
        exp_q.delete();
        for (int i = 0; i < 1024; i++) exp_q.push_back(start + 8'(i));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic redirect(input logic [7:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        seed(pc);
    endtask

    task automatic wait_first_wait(input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            hit = imem_req && !imem_ack && cnt == 1;
        end
        if (!hit) fail(name);
    endtask

    task automatic expect_head(input string name, input logic [7:0] pc);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (id_valid) seen = 1'b1;
            else tick();
        end
        if (seen) check(name, id_pc, pc);
        else fail(name);
    endtask

    // memory: ack after cur_ws wait cycles; also checks the request is held until ack
    initial begin
        bit prev_pend = 1'b0;
        logic [7:0] prev_addr = 8'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                imem_ack = 1'b1;
                cnt = 0;
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    check("req_hold", imem_req, 1);
                    check("addr_hold", imem_addr, prev_addr);
                end
                if (imem_req) begin
                    if (cnt == 0) cur_ws = rand_ws ? int'($urandom_range(0, 3)) : ws;
                    imem_ack = (cnt == cur_ws);
                    cnt = imem_ack ? 0 : cnt + 1;
                end else begin
                    imem_ack = 1'b0;
                    cnt = 0;
                end
                prev_pend = imem_req && !imem_ack;
                prev_addr = imem_addr;
            end
            imem_rdata = imem_ack ? mem(imem_addr) : 16'hDEAD;
        end
    end

    // monitor: every consumed head is compared against the scoreboard front
    initial begin
        logic [7:0] e;
        logic [15:0] d;
        int idle = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && id_valid && id_ready && !redirect_valid) begin
                pop_cyc.push_back(cyc);
                idle = 0;
                if (exp_q.size() == 0) begin
                    fail("sb_empty");
                end else begin
                    e = exp_q.pop_front();
                    d = mem(e);
                    check("id_pc", id_pc, e);
                    check("id_instr", id_instr, d);
                    check("id_op", id_op, d[15:12]);
                end
            end else if (rst_n && id_ready && !redirect_valid) begin
                idle++;
                if (idle == 24) begin
                    fail("stall_timeout");
                    idle = 0;
                end
            end else begin
                idle = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        seed(RPC);
        id_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, RPC);
        check("rst_valid", id_valid, 0);
        check("rst_instr", id_instr, 0);
        check("rst_op", id_op, 0);
        check("rst_pc", id_pc, 0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("boot_req", imem_req, 1);
        check("boot_addr", imem_addr, RPC);
        check("boot_valid", id_valid, 0);
        tick();
        @(negedge clk);
        check("first_valid", id_valid, 1);
        check("first_pc", id_pc, RPC);
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            check("stream_valid", id_valid, 1);
        end
        // backpressure: queue fills, request drops, head frozen
        tick();
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_head", id_pc, exp_q[0]);
            if (i == 4) begin
                check("bp_req", imem_req, 0);
                check("bp_valid", id_valid, 1);
            end
            tick();
        end
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_release_valid", id_valid, 1);
            tick();
        end
        // three wait states: one instruction every four cycles
        ws = 3;
        pop_cyc.delete();
        repeat (40) tick();
        n = pop_cyc.size();
        check("ws_gap1", pop_cyc[n-1] - pop_cyc[n-2], 4);
        check("ws_gap2", pop_cyc[n-2] - pop_cyc[n-3], 4);
        // redirect with the queue full and nothing in flight
        ws = 0;
        id_ready = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        check("full_req", imem_req, 0);
        check("full_valid", id_valid, 1);
        tick();
        redirect(8'h40);
        id_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_valid_next", id_valid, 0);
        check("redir_addr", imem_addr, 8'h40);
        tick();
        @(negedge clk);
        check("redir_first_valid", id_valid, 1);
        check("redir_first_pc", id_pc, 8'h40);
        tick();
        @(negedge clk);
        check("redir_second_pc", id_pc, 8'h41);
        repeat (3) tick();
        // redirect while a slow fetch is outstanding
        ws = 3;
        wait_first_wait("wait_req1");
        redirect(8'h80);
        tick();
        redirect_valid = 1'b0;
        expect_head("drain_redir", 8'h80);
        wait_first_wait("wait_req2");
        redirect(8'h80);
        tick();
        redirect(8'h90);
        tick();
        redirect_valid = 1'b0;
        expect_head("drain_redir2", 8'h90);
        // second redirect lands on the same cycle as the drained ack
        wait_first_wait("wait_req3");
        redirect(8'hA0);
        repeat (3) tick();
        redirect(8'hB0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("drain_ack_req", imem_req, 1);
        check("drain_ack_addr", imem_addr, 8'hB0);
        expect_head("drain_ack_head", 8'hB0);
        // redirect coinciding with ack and pop, wrapping FE, FF, 00
        ws = 0;
        repeat (8) tick();
        check("sim_req", imem_req, 1);
        check("sim_valid", id_valid, 1);
        redirect(RPC);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("sim_valid_next", id_valid, 0);
        check("sim_addr", imem_addr, RPC);
        expect_head("wrap_first", RPC);
        repeat (4) tick();
        // randomized traffic
        rand_ws = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            tick();
            redirect_valid = 1'b0;
            id_ready = $urandom_range(0, 9) < 7;
            if ($urandom_range(0, 31) == 0) redirect(8'($urandom));
        end
        tick();
        redirect_valid = 1'b0;
        rand_ws = 1'b0;
        ws = 0;
        id_ready = 1'b1;
        repeat (6) tick();
        // asynchronous reset in the middle of a stream
        #1 rst_n = 1'b0;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_addr", imem_addr, RPC);
        check("arst_valid", id_valid, 0);
        check("arst_pc", id_pc, 0);
        seed(RPC);
        tick();
        tick();
        rst_n = 1'b1;
        expect_head("arst_restart", RPC);
        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage of the MIPS core. It sits directly upstream of the opcode decoder and drives the 4-bit `id_op` field that the decoder turns into `pc_src`/`st_data`. It owns the program counter and issues requests to instruction memory over a req/ack handshake with one request outstanding. Fetched words go into a 2-entry IF/ID queue drained by decode. A taken `bnz` resolved downstream arrives as a redirect, which flushes the queue and discards any in-flight fetch.

## Interface
Parameters:
- `ADDR_W`, 8, instruction-memory word-address width
- `INSTR_W`, 16, instruction width; opcode is `instr[INSTR_W-1 -: 4]`
- `RESET_PC`, 0, PC value loaded at reset

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `imem_req`  out  1  fetch request, registered
- `imem_addr`  out  ADDR_W  fetch word address, registered
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; valid only while `imem_req`=1
- `imem_rdata`  in  INSTR_W  fetched instruction
- `id_valid`  out  1  queue head valid
- `id_instr`  out  INSTR_W  queue head instruction
- `id_op`  out  4  queue head opcode, feeds the decoder
- `id_pc`  out  ADDR_W  address of the queue head
- `id_ready`  in  1  decode consumes the head when `id_valid & id_ready`
- `redirect_valid`  in  1  one-cycle pulse: taken branch, flush and refetch
- `redirect_pc`  in  ADDR_W  new fetch address

## Operation
- Storage:
  - `pc`: next address to request.
  - Queue: 2 entries of {instr, pc}, with `occ` in 0..2.
  - FSM state: FETCH or DRAIN.
- Head outputs:
  - `id_valid` = (`occ`!=0).
  - `id_instr`, `id_op` and `id_pc` come combinationally from the head entry.
  - When `occ`=0, these outputs hold stale values and decode must ignore them.
- Per-cycle events:
  - pop = `id_valid & id_ready`.
  - land = `imem_req & imem_ack`.
- FETCH, no redirect:
  - On land: push {`imem_rdata`, `imem_addr`}, then `pc` <= `imem_addr`+1.
  - On pop: drop the head.
  - Push and pop can happen in the same cycle, so `occ` is unchanged.
  - `occ_next` = `occ` + land − pop.
  - Next-cycle `imem_req`:
    - If a request is pending and not acked, `imem_req` and `imem_addr` are held unchanged until ack.
    - Otherwise `imem_req` <= (`occ_next` ≤ 1), and `imem_addr` <= the updated `pc`.
- Redirect (priority over pop and land in the same cycle):
  - `occ` <= 0 and `pc` <= `redirect_pc`.
  - Any same-cycle land or pop is discarded.
  - If `imem_req`=1 and `imem_ack`=0, go to DRAIN and keep `imem_req`/`imem_addr` unchanged.
  - Otherwise stay in FETCH, with `imem_req` <= 1 and `imem_addr` <= `redirect_pc`.
- DRAIN:
  - `imem_req` stays high with the old address; `occ` stays 0.
  - On ack: discard the data, go to FETCH, `imem_req` <= 1, `imem_addr` <= `pc`.
  - A redirect in DRAIN only updates `pc` (last redirect wins). If it coincides with the ack, the ack rules above still apply.
- `pc` and `imem_addr` wrap modulo 2^ADDR_W; fetching 2^ADDR_W−1 is followed by fetching 0.
- The queue never overflows: a request is only issued when a slot is guaranteed at landing.
  - A land with `occ`=2 in FETCH is a memory protocol violation; behaviour is undefined and is a verification assertion.

## Timing
- Reset (async assert):
  - `imem_req`=0, `imem_addr`=RESET_PC, `pc`=RESET_PC, `occ`=0, state FETCH.
  - `id_valid`=0, `id_instr`=0, `id_op`=0, `id_pc`=0.
- Reset asserted mid-operation aborts everything immediately; an ack arriving during reset is ignored.
- First edge after `rst_n` rises: `imem_req` <= 1 with address RESET_PC.
- Fetch latency:
  - With zero-wait memory (ack in the same cycle as req), an instruction is visible on `id_valid` one cycle after its req cycle.
  - Sustained throughput is 1 instruction/cycle while `id_ready`=1.
- Stall behaviour: with `id_ready`=0, the queue fills to 2 and `imem_req` then drops. `imem_req` rises again the edge after the pop that leaves `occ`=1.
- Redirect:
  - `id_valid`=0 in the cycle after the pulse.
  - With zero-wait memory, the first instruction at `redirect_pc` appears two cycles after the pulse.
  - Each wait state of a drained in-flight fetch adds one cycle.

## Test plan
- Reset and stream:
  - Stimulus: zero-wait memory returning data = 0x1000+addr, `id_ready`=1.
  - Required: `id_pc` sequence 0,1,2,… on consecutive cycles, `id_op`=1, and no bubbles after the first.
- Backpressure:
  - Stimulus: hold `id_ready`=0 for 5 cycles.
  - Required: `occ` reaches 2, `imem_req`=0, and the head stays fixed. On release, the pcs continue with no loss or duplication.
- Wait-state memory:
  - Stimulus: ack delayed 3 cycles.
  - Required: `imem_addr` stable for the whole request, and one instruction per 4 cycles.
- Redirect with no fetch in flight:
  - Stimulus: pulse `redirect_pc`=0x40 while `occ`=2.
  - Required: `id_valid`=0 next cycle, then `id_pc`=0x40, 0x41.
- Redirect during outstanding fetch:
  - Stimulus: 3-cycle ack latency, redirect to 0x80 in the first wait cycle.
  - Required: the old-address data is dropped and the next `id_pc` is 0x80. A second redirect to 0x90 during DRAIN results in 0x90.
- Wrap and simultaneous events:
  - Stimulus: `RESET_PC`=0xFE with a redirect coinciding with ack and pop.
  - Required: fetch order FE, FF, 00; the redirect wins and both the ack data and the pop are discarded.
